// File: rtl/cdu_mode_sequencer.sv
// cdu_mode_sequencer
//
// Sequences the CDU digital-mode commands (ISSZ / ISSCA / ISSEEC) for the ISS
// discrete interface. Zero, coarse-align and error-counter-enable requests
// are arbitrated (zero > coarse > eec). Mode changes happen only on clocks
// where faz_tick is high, so the downstream FAZ2-synchronised latches never
// see a mid-phase edge. A minimum CDU-zero hold and a post-zero settle
// interval are enforced.
//
// Optional feature: define CDU_COARSE_TIMEOUT_EN to bound coarse-align to
// COARSE_MAX_TICKS ticks. A timeout returns to IDLE and raises the sticky
// fault flag, which blocks COARSE until a tick with coarse_req low.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   faz_tick   in   one-clk strobe per FAZ2 period; the only clocks that advance
//   zero_req   in   CDU zero request (level)
//   coarse_req in   coarse-align request (level)
//   eec_req    in   error-counter-enable request (level)
//   issz       out  CDU zero command (registered)
//   issca      out  coarse-align command (registered)
//   isseec     out  error-counter-enable command (registered)
//   busy       out  high in ZERO or SETTLE
//   state      out  encoded state: IDLE=0 ZERO=1 SETTLE=2 EEC=3 COARSE=4
//   fault      out  sticky coarse-align timeout flag (0 without the macro)

module cdu_mode_sequencer #(
    parameter int ZERO_MIN_TICKS   = 16,
    parameter int SETTLE_TICKS     = 8,
    parameter int COARSE_MAX_TICKS = 64,
    parameter int CNT_W            = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       faz_tick,
    input  logic       zero_req,
    input  logic       coarse_req,
    input  logic       eec_req,
    output logic       issz,
    output logic       issca,
    output logic       isseec,
    output logic       busy,
    output logic [2:0] state,
    output logic       fault
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ZERO   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_EEC    = 3'd3,
        ST_COARSE = 3'd4
    } state_t;

    // Tick counts must be representable as a final counter value.
    if (ZERO_MIN_TICKS < 1 || ZERO_MIN_TICKS > (1 << CNT_W) ||
        SETTLE_TICKS < 1 || SETTLE_TICKS > (1 << CNT_W) ||
        COARSE_MAX_TICKS < 1 || COARSE_MAX_TICKS > (1 << CNT_W)) begin : g_param_check
        $error("cdu_mode_sequencer: tick parameter out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] ZERO_LAST   = CNT_W'(ZERO_MIN_TICKS - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_TICKS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             issz_q, issz_d;
    logic             issca_q, issca_d;
    logic             isseec_q, isseec_d;
    logic             busy_q, busy_d;
    logic             coarse_blocked;
    logic             counting;

`ifdef CDU_COARSE_TIMEOUT_EN
    localparam logic [CNT_W-1:0] COARSE_LAST = CNT_W'(COARSE_MAX_TICKS - 1);
    logic fault_q, fault_d;

    assign coarse_blocked = fault_q;
    assign fault          = fault_q;
`else
    assign coarse_blocked = 1'b0;
    assign fault          = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        counting = 1'b0;
`ifdef CDU_COARSE_TIMEOUT_EN
        fault_d  = fault_q;
`endif

        if (faz_tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (zero_req)                           state_d = ST_ZERO;
                    else if (coarse_req && !coarse_blocked) state_d = ST_COARSE;
                    else if (eec_req)                       state_d = ST_EEC;
                end
                ST_ZERO: begin
                    counting = 1'b1;
                    // A released request still holds ZERO until the minimum is met.
                    if (cnt_q >= ZERO_LAST && !zero_req) state_d = ST_SETTLE;
                end
                ST_SETTLE: begin
                    counting = 1'b1;
                    if (zero_req)                  state_d = ST_ZERO;
                    else if (cnt_q == SETTLE_LAST) state_d = ST_IDLE;
                end
                ST_EEC: begin
                    if (zero_req)                           state_d = ST_ZERO;
                    else if (coarse_req && !coarse_blocked) state_d = ST_COARSE;
                    else if (!eec_req)                      state_d = ST_IDLE;
                end
                ST_COARSE: begin
`ifdef CDU_COARSE_TIMEOUT_EN
                    counting = 1'b1;
`endif
                    if (zero_req)      state_d = ST_ZERO;
                    else if (!coarse_req) state_d = eec_req ? ST_EEC : ST_IDLE;
`ifdef CDU_COARSE_TIMEOUT_EN
                    else if (cnt_q == COARSE_LAST) begin
                        state_d = ST_IDLE;
                        fault_d = 1'b1;
                    end
`endif
                end
                default: state_d = ST_IDLE;
            endcase

`ifdef CDU_COARSE_TIMEOUT_EN
            if (!coarse_req) fault_d = 1'b0;
`endif

            // Any state change restarts the count; otherwise saturate at all-ones.
            if (state_d != state_q)              cnt_d = '0;
            else if (counting && cnt_q != '1)    cnt_d = cnt_q + 1'b1;
        end

        // Outputs decoded from the next state so they register with it in one update.
        issz_d   = (state_d == ST_ZERO);
        issca_d  = (state_d == ST_COARSE);
        isseec_d = (state_d == ST_COARSE) || (state_d == ST_EEC);
        busy_d   = (state_d == ST_ZERO) || (state_d == ST_SETTLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            issz_q   <= 1'b0;
            issca_q  <= 1'b0;
            isseec_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            issz_q   <= issz_d;
            issca_q  <= issca_d;
            isseec_q <= isseec_d;
            busy_q   <= busy_d;
        end
    end

`ifdef CDU_COARSE_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) fault_q <= 1'b0;
        else     fault_q <= fault_d;
    end
`endif

    assign issz   = issz_q;
    assign issca  = issca_q;
    assign isseec = isseec_q;
    assign busy   = busy_q;
    assign state  = state_q;

endmodule

// File: tb/tb_cdu_mode_sequencer.sv
// Self-checking bench for cdu_mode_sequencer. A tick-level reference model of
// the mode rules (mode, ticks spent in mode, fault) predicts every output.

module tb_cdu_mode_sequencer;

    localparam int ZERO_MIN   = 16;
    localparam int SETTLE_T   = 8;
    localparam int COARSE_MAX = 64;
    localparam int CW         = 8;
    localparam int SAT        = (1 << CW) - 1;
`ifdef CDU_COARSE_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam int M_IDLE = 0, M_ZERO = 1, M_SETTLE = 2, M_EEC = 3, M_COARSE = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       faz_tick = 1'b0;
    logic       zero_req = 1'b0;
    logic       coarse_req = 1'b0;
    logic       eec_req = 1'b0;
    logic       issz, issca, isseec, busy, fault;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;

    int m_mode;
    int m_dwell;
    bit m_fault;

    wire [7:0] obs = {issz, issca, isseec, busy, state, fault};

    cdu_mode_sequencer #(
        .ZERO_MIN_TICKS  (ZERO_MIN),
        .SETTLE_TICKS    (SETTLE_T),
        .COARSE_MAX_TICKS(COARSE_MAX),
        .CNT_W           (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .faz_tick  (faz_tick),
        .zero_req  (zero_req),
        .coarse_req(coarse_req),
        .eec_req   (eec_req),
        .issz      (issz),
        .issca     (issca),
        .isseec    (isseec),
        .busy      (busy),
        .state     (state),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    // Reference model: expected output vector from the current mode.
    function automatic logic [7:0] expected();
        logic [2:0] s;
        s = 3'(m_mode);
        return {m_mode == M_ZERO, m_mode == M_COARSE,
                (m_mode == M_EEC) || (m_mode == M_COARSE),
                (m_mode == M_ZERO) || (m_mode == M_SETTLE), s, m_fault};
    endfunction

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_dwell = 0;
        m_fault = 1'b0;
    endtask

    // One faz tick of the mode rules; m_dwell = ticks already spent in this mode.
    task automatic model_tick(input bit z, input bit c, input bit e);
        int nxt;
        bit nf;
        nxt = m_mode;
        nf  = m_fault;
        case (m_mode)
            M_IDLE:   if (z) nxt = M_ZERO;
                      else if (c && !m_fault) nxt = M_COARSE;
                      else if (e) nxt = M_EEC;
            M_ZERO:   if (!z && m_dwell + 1 >= ZERO_MIN) nxt = M_SETTLE;
            M_SETTLE: if (z) nxt = M_ZERO;
                      else if (m_dwell + 1 == SETTLE_T) nxt = M_IDLE;
            M_EEC:    if (z) nxt = M_ZERO;
                      else if (c && !m_fault) nxt = M_COARSE;
                      else if (!e) nxt = M_IDLE;
            M_COARSE: if (z) nxt = M_ZERO;
                      else if (!c) nxt = e ? M_EEC : M_IDLE;
                      else if (TIMEOUT_EN && m_dwell + 1 == COARSE_MAX) begin
                          nxt = M_IDLE;
                          nf  = 1'b1;
                      end
            default:  nxt = M_IDLE;
        endcase
        if (!c) nf = 1'b0;
        if (nxt != m_mode) m_dwell = 0;
        else if (m_dwell < SAT) m_dwell++;
        m_mode  = nxt;
        m_fault = nf;
    endtask

    // One clock: drive at negedge, model on posedge, return at next negedge.
    task automatic step(input bit t, input bit z, input bit c, input bit e);
        faz_tick   = t;
        zero_req   = z;
        coarse_req = c;
        eec_req    = e;
        @(posedge clk);
        if (!rst && t) model_tick(z, c, e);
        @(negedge clk);
    endtask

    // A non-tick clock with random requests, then the tick clock.
    task automatic tick_step(input bit z, input bit c, input bit e);
        step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
        step(1'b1, z, c, e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b1);
            total++;
            if (obs !== 8'h00) begin
                bad++;
                $display("[TB] FAIL reset cyc=%0d: got %b want %b", i, obs, 8'h00);
            end
        end
        rst = 1'b0;
        step(1'b1, 1'b1, 1'b1, 1'b1);
        total++;
        if (obs !== expected() || issz !== 1'b1 || state !== 3'd1) begin
            bad++;
            $display("[TB] FAIL reset_first_tick: got %b want %b", obs, expected());
        end
    endtask

    task automatic test_hold();
        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
            total++;
            if (obs !== expected()) begin
                bad++;
                $display("[TB] FAIL hold cyc=%0d: got %b want %b", i, obs, expected());
            end
        end
    endtask

    task automatic test_zero_min();
        int n_zero;
        int n_settle;
        n_zero   = 0;
        n_settle = 0;
        do_reset();
        for (int i = 0; i < 30; i++) begin
            tick_step(i == 0, 1'b0, 1'b0);
            if (issz === 1'b1) n_zero++;
            if (state === 3'd2) n_settle++;
            total++;
            if (obs !== expected()) begin
                bad++;
                $display("[TB] FAIL zero_min tick=%0d: got %b want %b", i, obs, expected());
            end
        end
        total++;
        if (n_zero != ZERO_MIN || n_settle != SETTLE_T) begin
            bad++;
            $display("[TB] FAIL zero_min_len: got zero=%0d settle=%0d want %0d/%0d",
                     n_zero, n_settle, ZERO_MIN, SETTLE_T);
        end
    endtask

    task automatic test_rezero();
        int n_zero;
        n_zero = 0;
        do_reset();
        // tick 0 enters ZERO, tick 16 enters SETTLE, tick 20 is the 4th SETTLE tick
        for (int i = 0; i < 50; i++) begin
            tick_step(i == 0 || i == 20, 1'b0, 1'b0);
            if (i >= 20 && issz === 1'b1) n_zero++;
            total++;
            if (obs !== expected()) begin
                bad++;
                $display("[TB] FAIL rezero tick=%0d: got %b want %b", i, obs, expected());
            end
        end
        total++;
        if (n_zero != ZERO_MIN) begin
            bad++;
            $display("[TB] FAIL rezero_len: got %0d want %0d", n_zero, ZERO_MIN);
        end
    endtask

    task automatic test_priority();
        bit z[5] = '{0, 0, 1, 0, 0};
        bit c[5] = '{0, 1, 1, 0, 1};
        bit e[5] = '{1, 1, 1, 1, 1};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick_step(z[i], c[i], e[i]);
            total++;
            if (obs !== expected()) begin
                bad++;
                $display("[TB] FAIL priority tick=%0d: got %b want %b", i, obs, expected());
            end
        end
    endtask

    task automatic test_coarse_exit();
        bit c[4] = '{1, 1, 0, 0};
        bit e[4] = '{1, 1, 1, 0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick_step(1'b0, c[i], e[i]);
            total++;
            if (obs !== expected()) begin
                bad++;
                $display("[TB] FAIL coarse_exit tick=%0d: got %b want %b", i, obs, expected());
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 203; i++) begin
            tick_step(1'b0, !(i == 200), 1'b0);
            total++;
            if (obs !== expected()) begin
                bad++;
                $display("[TB] FAIL timeout tick=%0d: got %b want %b", i, obs, expected());
            end
            if (i == 199) begin
                total++;
                if (fault !== TIMEOUT_EN || state !== (TIMEOUT_EN ? 3'd0 : 3'd4)) begin
                    bad++;
                    $display("[TB] FAIL timeout_end: got fault=%b state=%0d", fault, state);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        tick_step(1'b1, 1'b0, 1'b0);
        tick_step(1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        total++;
        if (obs !== 8'h00) begin
            bad++;
            $display("[TB] FAIL async_reset: got %b want %b", obs, 8'h00);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        bit t, z, c, e;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            t = ($urandom_range(0, 2) == 0);
            z = ($urandom_range(0, 11) == 0);
            c = ($urandom_range(0, 3) != 0);
            e = 1'($urandom);
            step(t, z, c, e);
            total++;
            if (obs !== expected()) begin
                bad++;
                $display("[TB] FAIL random cyc=%0d: got %b want %b", i, obs, expected());
            end
        end
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_hold();
        test_zero_min();
        test_rezero();
        test_priority();
        test_coarse_exit();
        test_timeout();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
